// File: rtl/c2s_req_handler_if.sv
// Packet-side and memory-bus-side signals of c2s_req_handler, bundled.
// The slave modport is the handler's view; the master modport is the C-side driver and bus model.
interface c2s_req_handler_if #(
  parameter int DATA_SIZE = 16
);
  logic                     req;
  logic                     ack;
  logic [31:0]              id;
  logic [31:0]              fn;
  logic [31:0]              addr;
  logic [32*DATA_SIZE-1:0]  data;
  logic [31:0]              ret;

  logic                     bus_req;
  logic                     bus_we;
  logic [31:0]              bus_addr;
  logic [31:0]              bus_wdata;
  logic [31:0]              bus_id;
  logic                     bus_gnt;
  logic                     bus_rvalid;
  logic [31:0]              bus_rdata;

  modport master (
    output req, id, fn, addr, data,
    input  ack, ret,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_id,
    output bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  req, id, fn, addr, data,
    output ack, ret,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_id,
    input  bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/c2s_req_handler.sv
// Consumes C-to-SV packets, executes the function code on a simple memory bus,
// and returns a 32-bit result through a four-phase req/ack handshake.
module c2s_req_handler #(
  parameter int DATA_SIZE = 16,
  parameter int TIMEOUT   = 1024,
  parameter int ADDR_STEP = 4
) (
  input logic              clk,
  input logic              rst_n,
  c2s_req_handler_if.slave c2s
);

  localparam int BW = $clog2(DATA_SIZE) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = 32 * (DATA_SIZE - 1);
  localparam int IW = $clog2(DW);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] WR      = 3'd2;
  localparam logic [2:0] RD      = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]    r_state;
  logic          r_req_meta;
  logic          r_req_s;
  logic [DW-1:0] r_data;      // payload words 1..DATA_SIZE-1; word 0 is consumed at CAPTURE
  logic [BW-1:0] r_beat;
  logic [BW-1:0] r_nbeats;
  logic [WW-1:0] r_wait;
  logic          r_ack;
  logic [31:0]   r_ret;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [31:0]   r_bus_id;

  logic [31:0]   w_burst_cnt;
  logic [BW-1:0] w_next_beat;
  logic [IW-1:0] w_sel;
  logic [31:0]   w_next_wdata;
  logic          w_timeout;

  assign w_burst_cnt = (c2s.data[31:0] > 32'(DATA_SIZE - 1)) ? 32'(DATA_SIZE - 1)
                                                             : c2s.data[31:0];
  assign w_next_beat = r_beat + BW'(1);
  assign w_sel       = IW'(32 * int'(w_next_beat));
  assign w_timeout   = (r_wait == WW'(TIMEOUT - 1));

  // Burst beat k+1 carries payload word k+2, i.e. captured word k+1.
  always_comb begin
    // NOTE: default first so no path leaves w_next_wdata unassigned (no latch).
    w_next_wdata = '0;
    if (int'(w_next_beat) < DATA_SIZE - 1)
      w_next_wdata = r_data[w_sel +: 32];
  end

  // NOTE: the payload store has no reset; it is only read after CAPTURE has written it.
  always_ff @(posedge clk) begin
    if (r_state == CAPTURE)
      r_data <= c2s.data[32*DATA_SIZE-1:32];
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_meta  <= 1'b0;
      r_req_s     <= 1'b0;
      r_beat      <= '0;
      r_nbeats    <= '0;
      r_wait      <= '0;
      r_ack       <= 1'b0;
      r_ret       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_id    <= '0;
    end else begin
      r_req_meta <= c2s.req;
      r_req_s    <= r_req_meta;

      case (r_state)
        IDLE: begin
          if (r_req_s && !r_ack)
            r_state <= CAPTURE;
        end

        CAPTURE: begin
          r_bus_id   <= c2s.id;
          r_bus_addr <= c2s.addr;
          r_beat     <= '0;
          r_wait     <= '0;
          r_ret      <= '0;
          case (c2s.fn)
            32'd0: begin
              r_ack   <= 1'b1;
              r_state <= DONE;
            end
            32'd1: begin
              r_nbeats    <= BW'(1);
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b1;
              r_bus_wdata <= c2s.data[31:0];
              r_state     <= WR;
            end
            32'd2: begin
              r_bus_req <= 1'b1;
              r_bus_we  <= 1'b0;
              r_state   <= RD;
            end
            32'd3: begin
              if (w_burst_cnt == 32'd0) begin
                r_ack   <= 1'b1;
                r_state <= DONE;
              end else begin
                r_nbeats    <= w_burst_cnt[BW-1:0];
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b1;
                r_bus_wdata <= c2s.data[63:32];
                r_state     <= WR;
              end
            end
            default: begin
              r_ret   <= 32'hFFFF_FFFF;
              r_ack   <= 1'b1;
              r_state <= DONE;
            end
          endcase
        end

        WR: begin
          if (c2s.bus_gnt) begin
            r_wait <= '0;
            if (w_next_beat < r_nbeats) begin
              r_beat      <= w_next_beat;
              r_bus_addr  <= r_bus_addr + 32'(ADDR_STEP);
              r_bus_wdata <= w_next_wdata;
            end else begin
              r_bus_req <= 1'b0;
              r_ret     <= 32'(r_nbeats);
              r_ack     <= 1'b1;
              r_state   <= DONE;
            end
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_ret     <= 32'hFFFF_FFFE;
            r_ack     <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end

        RD: begin
          if (c2s.bus_gnt) begin
            r_bus_req <= 1'b0;
            r_wait    <= '0;
            if (c2s.bus_rvalid) begin
              r_ret   <= c2s.bus_rdata;
              r_ack   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= RD_WAIT;
            end
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_ret     <= 32'hFFFF_FFFE;
            r_ack     <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end

        RD_WAIT: begin
          if (c2s.bus_rvalid) begin
            r_ret   <= c2s.bus_rdata;
            r_ack   <= 1'b1;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_ret   <= 32'hFFFF_FFFE;
            r_ack   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end

        DONE: begin
          if (!r_req_s) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign c2s.ack       = r_ack;
  assign c2s.ret       = r_ret;
  assign c2s.bus_req   = r_bus_req;
  assign c2s.bus_we    = r_bus_we;
  assign c2s.bus_addr  = r_bus_addr;
  assign c2s.bus_wdata = r_bus_wdata;
  assign c2s.bus_id    = r_bus_id;

endmodule

// File: tb/tb_c2s_req_handler.sv
// Randomized self-checking bench for c2s_req_handler: a packet driver, a bus responder
// that logs every granted beat, and a transaction-level model of the expected beats and result.
module tb_c2s_req_handler;

  localparam int DATA_SIZE = 16;
  localparam int TIMEOUT   = 64;
  localparam int ADDR_STEP = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] id;
  } beat_t;

  logic clk;
  logic rst_n;

  c2s_req_handler_if #(.DATA_SIZE(DATA_SIZE)) tif ();

  c2s_req_handler #(
    .DATA_SIZE (DATA_SIZE),
    .TIMEOUT   (TIMEOUT),
    .ADDR_STEP (ADDR_STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c2s   (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus responder knobs, set by the stimulus before each packet.
  int          gnt_delay  = 0;
  int          rv_delay   = 0;
  bit          gnt_never  = 1'b0;
  logic [31:0] rd_value   = '0;

  beat_t       seen_q[$];
  beat_t       exp_q[$];
  logic [31:0] id_log[$];
  int          req_cycles = 0;
  bit          overlap    = 1'b0;

  int g_cnt   = 0;
  int rv_cnt  = 0;
  bit rv_pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      tif.bus_gnt    = 1'b0;
      tif.bus_rvalid = 1'b0;
      g_cnt          = 0;
      rv_pend        = 1'b0;
    end else begin
      tif.bus_gnt    = 1'b0;
      tif.bus_rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          tif.bus_rvalid = 1'b1;
          tif.bus_rdata  = rd_value;
          rv_pend        = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      if (tif.bus_req) begin
        req_cycles++;
        if (tif.ack) overlap = 1'b1;
        if (!gnt_never) begin
          if (g_cnt >= gnt_delay) begin
            tif.bus_gnt = 1'b1;
            g_cnt       = 0;
            seen_q.push_back('{tif.bus_we, tif.bus_addr, tif.bus_wdata, tif.bus_id});
            id_log.push_back(tif.bus_id);
            if (!tif.bus_we) begin
              if (rv_delay == 0) begin
                tif.bus_rvalid = 1'b1;
                tif.bus_rdata  = rd_value;
              end else begin
                rv_pend = 1'b1;
                rv_cnt  = rv_delay - 1;
              end
            end
          end else begin
            g_cnt++;
          end
        end
      end else begin
        g_cnt = 0;
      end
    end
  end

  logic [31:0] pd[DATA_SIZE];

  // Transaction-level expectation: which beats the bus should see and what ret must be.
  task automatic model(input logic [31:0] f, input logic [31:0] a, input logic [31:0] pid,
                       output logic [31:0] r);
    int n;
    exp_q.delete();
    case (f)
      32'd0: r = 32'd0;
      32'd1: begin
        exp_q.push_back('{1'b1, a, pd[0], pid});
        r = 32'd1;
      end
      32'd2: begin
        if (gnt_never) r = 32'hFFFF_FFFE;
        else begin
          exp_q.push_back('{1'b0, a, 32'd0, pid});
          r = rd_value;
        end
      end
      32'd3: begin
        n = (pd[0] > 32'(DATA_SIZE - 1)) ? DATA_SIZE - 1 : int'(pd[0]);
        for (int k = 0; k < n; k++)
          exp_q.push_back('{1'b1, a + 32'(k * ADDR_STEP), pd[k + 1], pid});
        r = 32'(n);
      end
      default: r = 32'hFFFF_FFFF;
    endcase
  endtask

  task automatic load_fields(input logic [31:0] p_id, input logic [31:0] p_fn,
                             input logic [31:0] p_addr);
    tif.id   = p_id;
    tif.fn   = p_fn;
    tif.addr = p_addr;
    for (int i = 0; i < DATA_SIZE; i++) tif.data[32*i +: 32] = pd[i];
  endtask

  task automatic run_packet(input string tag, input logic [31:0] p_id, input logic [31:0] p_fn,
                            input logic [31:0] p_addr, output int lat);
    logic [31:0] exp_ret;
    bit got;
    bit fell;
    int n;
    int m;
    model(p_fn, p_addr, p_id, exp_ret);
    seen_q.delete();
    req_cycles = 0;
    load_fields(p_id, p_fn, p_addr);
    @(posedge clk);
    #1 tif.req = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4 * TIMEOUT + 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (tif.ack) got = 1'b1;
    end
    check({tag, " ack_rise"}, 32'(got), 32'd1);
    check({tag, " ret"}, tif.ret, exp_ret);
    @(negedge clk);
    check({tag, " ack_held"}, 32'(tif.ack), 32'd1);
    tif.req = 1'b0;
    fell = 1'b0;
    n = 0;
    while (!fell && n < 8) begin
      @(negedge clk);
      n++;
      if (!tif.ack) fell = 1'b1;
    end
    check({tag, " ack_fall"}, 32'(fell), 32'd1);
    check({tag, " ret_hold"}, tif.ret, exp_ret);
    check({tag, " beat_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
    m = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s beat%0d addr", tag, i), seen_q[i].addr, exp_q[i].addr);
      check($sformatf("%s beat%0d we", tag, i), 32'(seen_q[i].we), 32'(exp_q[i].we));
      check($sformatf("%s beat%0d id", tag, i), seen_q[i].id, exp_q[i].id);
      if (exp_q[i].we)
        check($sformatf("%s beat%0d wdata", tag, i), seen_q[i].wdata, exp_q[i].wdata);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ack"}, 32'(tif.ack), 32'd0);
    check({tag, " ret"}, tif.ret, 32'd0);
    check({tag, " bus_req"}, 32'(tif.bus_req), 32'd0);
    check({tag, " bus_we"}, 32'(tif.bus_we), 32'd0);
    check({tag, " bus_addr"}, tif.bus_addr, 32'd0);
    check({tag, " bus_wdata"}, tif.bus_wdata, 32'd0);
    check({tag, " bus_id"}, tif.bus_id, 32'd0);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < DATA_SIZE; i++) pd[i] = $urandom;
  endtask

  initial begin
    int lat;
    int n;
    rst_n          = 1'b0;
    tif.req        = 1'b0;
    tif.id         = '0;
    tif.fn         = '0;
    tif.addr       = '0;
    tif.data       = '0;
    tif.bus_gnt    = 1'b0;
    tif.bus_rvalid = 1'b0;
    tif.bus_rdata  = '0;
    randomize_payload();

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NOP latency and result.
    run_packet("nop", 32'd1, 32'd0, 32'h40, lat);
    check("nop latency", 32'(lat), 32'd4);

    // Single write, zero-wait bus.
    pd[0] = 32'hCAFE_0001;
    gnt_delay = 0;
    run_packet("wr0", 32'd2, 32'd1, 32'h100, lat);
    check("wr0 latency", 32'(lat), 32'd5);

    // Single write with two wait cycles before the grant.
    gnt_delay = 2;
    run_packet("wr2", 32'd3, 32'd1, 32'h100, lat);

    // Single read: rvalid three cycles after gnt, then in the gnt cycle.
    gnt_delay = 0;
    rv_delay  = 3;
    rd_value  = 32'h1234_5678;
    run_packet("rd3", 32'd4, 32'd2, 32'h200, lat);
    rv_delay = 0;
    run_packet("rd0", 32'd4, 32'd2, 32'h200, lat);

    // Burst clamped to DATA_SIZE-1, then an empty burst.
    randomize_payload();
    pd[0] = 32'd20;
    run_packet("burst20", 32'd7, 32'd3, 32'h0, lat);
    pd[0] = 32'd0;
    run_packet("burst0", 32'd8, 32'd3, 32'h0, lat);
    check("burst0 no bus_req", 32'(req_cycles), 32'd0);

    // Unknown function code and read timeout.
    run_packet("fn7", 32'd9, 32'd7, 32'h300, lat);
    check("fn7 no bus_req", 32'(req_cycles), 32'd0);
    gnt_never = 1'b1;
    run_packet("rd_to", 32'd10, 32'd2, 32'h400, lat);
    check("rd_to bus_req cycles", 32'(req_cycles), 32'(TIMEOUT));
    gnt_never = 1'b0;

    // Back-to-back packets: ids must reach the bus in order and never overlap ack.
    id_log.delete();
    overlap = 1'b0;
    gnt_delay = 1;
    run_packet("b2b5", 32'd5, 32'd1, 32'h500, lat);
    run_packet("b2b6", 32'd6, 32'd1, 32'h504, lat);
    check("b2b id count", 32'(id_log.size()), 32'd2);
    if (id_log.size() == 2) begin
      check("b2b id first", id_log[0], 32'd5);
      check("b2b id second", id_log[1], 32'd6);
    end
    check("b2b overlap", 32'(overlap), 32'd0);

    // Randomized packets against the model.
    for (int it = 0; it < 24; it++) begin
      int          sel;
      logic [31:0] f;
      randomize_payload();
      gnt_delay = $urandom_range(0, 3);
      rv_delay  = $urandom_range(0, 3);
      rd_value  = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: f = 32'(sel);
        3, 4: begin
          f     = 32'd3;
          pd[0] = 32'($urandom_range(0, 20));
        end
        default: f = 32'($urandom_range(4, 1000));
      endcase
      run_packet($sformatf("rnd%0d", it), $urandom, f, $urandom & 32'hFFFF_FFFC, lat);
    end

    // Reset in the middle of a burst, then a fresh NOP.
    randomize_payload();
    pd[0] = 32'd8;
    gnt_delay = 0;
    seen_q.delete();
    load_fields(32'd11, 32'd3, 32'h800);
    @(posedge clk);
    #1 tif.req = 1'b1;
    n = 0;
    while (seen_q.size() < 3 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("midrst reached beat3", 32'(seen_q.size() >= 3), 32'd1);
    rst_n   = 1'b0;
    tif.req = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    check_outputs_zero("midrst held");
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_packet("post_rst_nop", 32'd12, 32'd0, 32'h0, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
